arith_seq_divider: RTL
======================

Name: arith_seq_divider

Overview:
- Iterative unsigned restoring divider; the sequential inverse companion of the team's combinational 8-bit arithmetic unit.
- Takes dividend/divisor operands over a valid/ready input handshake, computes one quotient bit per cycle, and presents quotient plus remainder over a valid/ready output handshake.
- Sits beside the combinational arithmetic unit where a registered, area-cheap divide is needed.

Parameters:
- WIDTH, 8, operand/result width in bits (min 2).

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  result came from a zero divisor
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, quotient=0, remainder=0, div_by_zero=0, internal counter/shift registers cleared. Applies immediately, including mid-CALC or mid-DONE. The in-flight operation is discarded and no result is emitted.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> CALC:
  - Triggered on an edge with in_valid=1 and divisor!=0.
  - Operands latch into internal registers.
  - Bit counter loads WIDTH; partial remainder clears to 0.
- IDLE -> DONE:
  - Triggered on an edge with in_valid=1 and divisor==0.
  - quotient = all ones, remainder = dividend, div_by_zero=1.
  - out_valid is visible 1 cycle after acceptance.
- CALC, one step per cycle:
  - Shift {partial_rem, dividend_shreg} left 1.
  - Trial = partial_rem - divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: partial_rem = trial and the new quotient LSB = 1; otherwise the LSB = 0.
  - Counter decrements.
  - After WIDTH steps, go to DONE, loading the quotient/remainder outputs with div_by_zero=0.
- Latency: out_valid rises exactly WIDTH cycles after the acceptance edge (8 for the default).
- Operand inputs are sampled only at acceptance. Later changes to dividend/divisor/in_valid have no effect until the block is back in IDLE.
- DONE:
  - quotient, remainder and div_by_zero hold stable while out_valid=1 and out_ready=0, with unlimited backpressure.
  - On an edge with out_ready=1: go to IDLE and clear out_valid. Output data registers keep their last values.
- No same-cycle pass-through: in_ready is 0 in DONE, so a new operand is accepted no earlier than the cycle after the result handshake. Minimum initiation interval is WIDTH+2 cycles.
- out_ready asserted outside DONE is ignored.
- Arithmetic: fully unsigned. Invariant for a non-zero divisor: quotient*divisor + remainder == dividend, and remainder < divisor. The internal subtractor is WIDTH+1 bits so a remainder near 2^WIDTH-1 does not wrap.
- busy = (state != IDLE).

Test Plan:
- Reset then 8/4 (in_valid 1 cycle) -> in_ready drops next cycle; out_valid rises 8 cycles after acceptance with quotient=2, remainder=0, div_by_zero=0; out_ready=1 returns to IDLE with in_ready=1.
- 255/16 -> quotient=15, remainder=15. Then 3/200 -> quotient=0, remainder=3. Then 200/1 -> quotient=200, remainder=0.
- 7/0 -> out_valid exactly 1 cycle after acceptance; quotient=255, remainder=7, div_by_zero=1.
- Backpressure: 100/7 with out_ready held low 5 cycles after out_valid -> quotient=14 and remainder=2 stable throughout; dividend/divisor changed to 9/3 during CALC do not alter the result.
- Reset mid-operation: accept 250/3, pull rst_n low 4 cycles in (asynchronously, between edges) -> outputs go to reset values immediately; after release, 9/3 -> quotient=3, remainder=0 with normal 8-cycle latency.
- Random sweep of 1000 operand pairs (including 0 and 255 dividends) -> invariant holds and latency = WIDTH for every non-zero divisor.

Source files
------------

// File: rtl/arith_seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, operands and
// results exchanged over valid/ready handshakes.
module arith_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends combinationally on ready on either side.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;

  // Partial remainder stays below the divisor, so a non-negative trial always
  // fits in WIDTH bits; both upper bits being clear means "no borrow".
  assign shifted  = {prem_q, dvd_q[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dvs_q};
  assign trial_ok = ~|trial[WIDTH+1:WIDTH];
  assign step_rem = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign step_dvd = {dvd_q[WIDTH-2:0], trial_ok};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            dvd_d   = dividend;
            dvs_d   = divisor;
            prem_d  = '0;
            cnt_d   = CW'(WIDTH);
          end
        end
      end
      CALC: begin
        prem_d = step_rem;
        dvd_d  = step_dvd;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quo_d   = step_dvd;
          rem_d   = step_rem;
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule
